// File: rtl/regfile_wb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_pkg
// Shared constants for the register-file writeback arbiter slice.
//   SRC_LOAD/SRC_ALU/SRC_HOST : fixed source index assignment
//   DEF_NUM_SRC/DEF_AW/DEF_DW : default parameter values
//   REG_ZERO                  : address of the hard-wired zero register
//   wrapInc()                 : modulo increment used for the round-robin pointer
// -----------------------------------------------------------------------------
package regfile_wb_pkg;

    localparam int SRC_LOAD = 0;
    localparam int SRC_ALU  = 1;
    localparam int SRC_HOST = 2;

    localparam int DEF_NUM_SRC = 3;
    localparam int DEF_AW      = 5;
    localparam int DEF_DW      = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Next index after idx in a ring of n entries.
    function automatic int wrapInc(input int idx, input int n);
        int nxt;
        nxt = idx + 1;
        if (nxt >= n) begin
            nxt = 0;
        end else begin
            nxt = idx + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the writeback request bus, the decode hazard query and the register
// file write port of regfile_wb_arbiter.
//   src_valid/src_ready/src_addr/src_data : per-source write requests (packed)
//   ReadRegster1/2, pend1/2               : decode read addresses and pending flags
//   RegWrite/WriteRegster/WriteData       : registered register-file write port
//   busy                                  : any write held or in flight
// Modports: slave = arbiter side, master = requester/consumer side.
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if
    import regfile_wb_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW
) ();

    logic [NUM_SRC-1:0]    src_valid;
    logic [NUM_SRC-1:0]    src_ready;
    logic [NUM_SRC*AW-1:0] src_addr;
    logic [NUM_SRC*DW-1:0] src_data;
    logic [AW-1:0]         ReadRegster1;
    logic [AW-1:0]         ReadRegster2;
    logic                  pend1;
    logic                  pend2;
    logic                  RegWrite;
    logic [AW-1:0]         WriteRegster;
    logic [DW-1:0]         WriteData;
    logic                  busy;

    modport slave (
        input  src_valid, src_addr, src_data, ReadRegster1, ReadRegster2,
        output src_ready, pend1, pend2, RegWrite, WriteRegster, WriteData, busy
    );

    modport master (
        output src_valid, src_addr, src_data, ReadRegster1, ReadRegster2,
        input  src_ready, pend1, pend2, RegWrite, WriteRegster, WriteData, busy
    );

endinterface

// File: rtl/wb_slot.sv
// -----------------------------------------------------------------------------
// wb_slot
// One-entry holding register for a single writeback source.
//   CK, CLR        : clock, asynchronous active-high clear
//   load           : capture inAddr/inData, slot becomes full
//   drain          : entry consumed by the arbiter, slot becomes empty
//   inAddr, inData : entry presented by the source
//   full/addr/data : current slot contents
// Load and drain on the same edge leave the slot full with the new entry.
// -----------------------------------------------------------------------------
module wb_slot
    import regfile_wb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          CK,
    input  logic          CLR,
    input  logic          load,
    input  logic          drain,
    input  logic [AW-1:0] inAddr,
    input  logic [DW-1:0] inData,
    output logic          full,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    // Slot state: load wins over drain so a refill on the grant edge is kept.
    always_ff @(posedge CK or posedge CLR) begin
        if (CLR) begin
            full <= 1'b0;
            addr <= {AW{1'b0}};
            data <= {DW{1'b0}};
        end else if (load) begin
            full <= 1'b1;
            addr <= inAddr;
            data <= inData;
        end else if (drain) begin
            full <= 1'b0;
        end else begin
            full <= full;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single write port of the register file among NUM_SRC writeback
// sources. Each source owns a one-entry slot; full slots are drained one per
// cycle in round-robin order onto the registered write port. Decode reads that
// hit a held or in-flight write are flagged through pend1/pend2.
//   CK   : clock, all state on posedge
//   CLR  : asynchronous active-high reset, discards every held write
//   bus  : regfile_wb_arbiter_if.slave (requests, hazard query, write port)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW
) (
    input  logic                  CK,
    input  logic                  CLR,
    regfile_wb_arbiter_if.slave   bus
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PW-1:0]      rrPtr;
    logic [NUM_SRC-1:0] slotFull;
    logic [AW-1:0]      slotAddr [NUM_SRC];
    logic [DW-1:0]      slotData [NUM_SRC];
    logic [AW-1:0]      srcAddr  [NUM_SRC];
    logic [NUM_SRC-1:0] grantVec;
    logic [NUM_SRC-1:0] readyVec;
    logic [NUM_SRC-1:0] loadVec;
    logic               grantValid;
    logic [PW-1:0]      grantIdx;
    logic               regWriteQ;
    logic [AW-1:0]      writeRegQ;
    logic [DW-1:0]      writeDataQ;
    logic               pend1Comb;
    logic               pend2Comb;

    genvar g;
    for (g = 0; g < NUM_SRC; g++) begin : gSlot
        assign srcAddr[g] = bus.src_addr[g*AW +: AW];

        wb_slot #(.AW(AW), .DW(DW)) uSlot (
            .CK     (CK),
            .CLR    (CLR),
            .load   (loadVec[g]),
            .drain  (grantVec[g]),
            .inAddr (bus.src_addr[g*AW +: AW]),
            .inData (bus.src_data[g*DW +: DW]),
            .full   (slotFull[g]),
            .addr   (slotAddr[g]),
            .data   (slotData[g])
        );
    end

    // Round-robin grant: first full slot at or after rrPtr, wrapping.
    always_comb begin
        int scanIdx;
        scanIdx    = 0;
        grantValid = 1'b0;
        grantIdx   = {PW{1'b0}};
        grantVec   = {NUM_SRC{1'b0}};
        for (int j = 0; j < NUM_SRC; j++) begin
            scanIdx = int'(rrPtr) + j;
            if (scanIdx >= NUM_SRC) begin
                scanIdx = scanIdx - NUM_SRC;
            end else begin
                scanIdx = int'(rrPtr) + j;
            end
            if (!grantValid && slotFull[scanIdx]) begin
                grantValid = 1'b1;
                grantIdx   = PW'(scanIdx);
            end else begin
                grantValid = grantValid;
            end
        end
        if (grantValid) begin
            grantVec[grantIdx] = 1'b1;
        end else begin
            grantVec = {NUM_SRC{1'b0}};
        end
    end

    // Slot accept with same-register ordering: a source is held off while an
    // older write to the same register is still waiting (a full, non-granted
    // slot) or is being accepted by a lower-index source this cycle. The
    // ready bits of lower sources are therefore resolved first.
    always_comb begin
        logic [NUM_SRC-1:0] rdyAcc;
        logic               conf;
        rdyAcc = {NUM_SRC{1'b0}};
        conf   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            conf = 1'b0;
            if (srcAddr[i] != AW'(REG_ZERO)) begin
                for (int j = 0; j < NUM_SRC; j++) begin
                    if ((j != i) && slotFull[j] && !grantVec[j] && (slotAddr[j] == srcAddr[i])) begin
                        conf = 1'b1;
                    end else if ((j < i) && bus.src_valid[j] && rdyAcc[j] && (srcAddr[j] == srcAddr[i])) begin
                        conf = 1'b1;
                    end else begin
                        conf = conf;
                    end
                end
            end else begin
                conf = 1'b0;
            end
            rdyAcc[i] = (!slotFull[i] || grantVec[i]) && !conf;
        end
        readyVec = rdyAcc;
    end

    assign loadVec       = bus.src_valid & readyVec;
    assign bus.src_ready = readyVec;

    // Write port and rotation pointer; an r0 entry drains and rotates but
    // never raises RegWrite. Address/data hold when idle.
    always_ff @(posedge CK or posedge CLR) begin
        if (CLR) begin
            rrPtr      <= {PW{1'b0}};
            regWriteQ  <= 1'b0;
            writeRegQ  <= {AW{1'b0}};
            writeDataQ <= {DW{1'b0}};
        end else if (grantValid) begin
            rrPtr      <= PW'(wrapInc(int'(grantIdx), NUM_SRC));
            regWriteQ  <= (slotAddr[grantIdx] != AW'(REG_ZERO));
            writeRegQ  <= slotAddr[grantIdx];
            writeDataQ <= slotData[grantIdx];
        end else begin
            rrPtr      <= rrPtr;
            regWriteQ  <= 1'b0;
            writeRegQ  <= writeRegQ;
            writeDataQ <= writeDataQ;
        end
    end

    // Decode hazard: read address matches a held entry or the write in flight.
    always_comb begin
        pend1Comb = 1'b0;
        pend2Comb = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (slotFull[i] && (bus.ReadRegster1 != AW'(REG_ZERO)) && (slotAddr[i] == bus.ReadRegster1)) begin
                pend1Comb = 1'b1;
            end else begin
                pend1Comb = pend1Comb;
            end
            if (slotFull[i] && (bus.ReadRegster2 != AW'(REG_ZERO)) && (slotAddr[i] == bus.ReadRegster2)) begin
                pend2Comb = 1'b1;
            end else begin
                pend2Comb = pend2Comb;
            end
        end
        if (regWriteQ && (bus.ReadRegster1 != AW'(REG_ZERO)) && (writeRegQ == bus.ReadRegster1)) begin
            pend1Comb = 1'b1;
        end else begin
            pend1Comb = pend1Comb;
        end
        if (regWriteQ && (bus.ReadRegster2 != AW'(REG_ZERO)) && (writeRegQ == bus.ReadRegster2)) begin
            pend2Comb = 1'b1;
        end else begin
            pend2Comb = pend2Comb;
        end
    end

    assign bus.pend1        = pend1Comb;
    assign bus.pend2        = pend2Comb;
    assign bus.RegWrite     = regWriteQ;
    assign bus.WriteRegster = writeRegQ;
    assign bus.WriteData    = writeDataQ;
    assign bus.busy         = (|slotFull) | regWriteQ;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Drives directed scenarios and random traffic into regfile_wb_arbiter and
// compares every cycle against a behavioural model of the slots, the grant
// rotation and the write port, plus a register-file image built from the
// order in which writes were accepted.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

    localparam int NS = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic CK  = 1'b0;
    logic CLR = 1'b1;

    always #5 CK = ~CK;

    regfile_wb_arbiter_if #(.NUM_SRC(NS), .AW(AW), .DW(DW)) bus ();

    regfile_wb_arbiter #(.NUM_SRC(NS), .AW(AW), .DW(DW)) dut (
        .CK  (CK),
        .CLR (CLR),
        .bus (bus)
    );

    int nChecks = 0;
    int nPass   = 0;

    // Behavioural model state
    logic          mFull [NS];
    logic [AW-1:0] mAddr [NS];
    logic [DW-1:0] mData [NS];
    int            mPtr;
    logic          mRw;
    logic [AW-1:0] mWa;
    logic [DW-1:0] mWd;
    logic [NS-1:0] accepted;
    logic [DW-1:0] lastAcc [32];
    logic [DW-1:0] tbFile  [32];

    logic [NS-1:0]    rV;
    logic [NS*AW-1:0] rA;
    logic [NS*DW-1:0] rD;

    // Register-file image as written by the DUT's write port.
    always @(posedge CK) begin
        if (CLR) begin
            for (int i = 0; i < 32; i++) tbFile[i] <= '0;
        end else if (bus.RegWrite) begin
            tbFile[bus.WriteRegster] <= bus.WriteData;
        end
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic doReset();
        @(negedge CK);
        CLR = 1'b1;
        bus.src_valid = '0;
        bus.src_addr  = '0;
        bus.src_data  = '0;
        bus.ReadRegster1 = 5'd5;
        bus.ReadRegster2 = 5'd7;
        #1;
        for (int i = 0; i < NS; i++) begin
            mFull[i] = 1'b0;
            mAddr[i] = '0;
            mData[i] = '0;
        end
        mPtr = 0; mRw = 1'b0; mWa = '0; mWd = '0;
        for (int i = 0; i < 32; i++) lastAcc[i] = '0;
        checkVal("rst_RegWrite", 64'(bus.RegWrite), 64'd0);
        checkVal("rst_WriteRegster", 64'(bus.WriteRegster), 64'd0);
        checkVal("rst_WriteData", 64'(bus.WriteData), 64'd0);
        checkVal("rst_pend1", 64'(bus.pend1), 64'd0);
        checkVal("rst_pend2", 64'(bus.pend2), 64'd0);
        checkVal("rst_busy", 64'(bus.busy), 64'd0);
        checkVal("rst_src_ready", 64'(bus.src_ready), 64'h7);
        @(negedge CK);
        CLR = 1'b0;
    endtask

    // One cycle: drive inputs, compare DUT against the model, advance the model.
    task automatic stepCycle(input logic [NS-1:0] v, input logic [NS*AW-1:0] a,
                             input logic [NS*DW-1:0] d, input logic [AW-1:0] r1,
                             input logic [AW-1:0] r2);
        int g;
        logic [NS-1:0] rdy;
        logic conf, anyFull, expP1, expP2;
        logic [AW-1:0] ai;
        @(negedge CK);
        bus.src_valid = v;
        bus.src_addr  = a;
        bus.src_data  = d;
        bus.ReadRegster1 = r1;
        bus.ReadRegster2 = r2;
        #1;
        checkVal("RegWrite", 64'(bus.RegWrite), 64'(mRw));
        checkVal("WriteRegster", 64'(bus.WriteRegster), 64'(mWa));
        checkVal("WriteData", 64'(bus.WriteData), 64'(mWd));
        anyFull = 1'b0; expP1 = 1'b0; expP2 = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (mFull[i]) begin
                anyFull = 1'b1;
                if (r1 != '0 && mAddr[i] == r1) expP1 = 1'b1;
                if (r2 != '0 && mAddr[i] == r2) expP2 = 1'b1;
            end
        end
        if (mRw && r1 != '0 && mWa == r1) expP1 = 1'b1;
        if (mRw && r2 != '0 && mWa == r2) expP2 = 1'b1;
        checkVal("busy", 64'(bus.busy), 64'(anyFull | mRw));
        checkVal("pend1", 64'(bus.pend1), 64'(expP1));
        checkVal("pend2", 64'(bus.pend2), 64'(expP2));
        g = -1;
        for (int j = 0; j < NS; j++) begin
            int k;
            k = (mPtr + j) % NS;
            if (g < 0 && mFull[k]) g = k;
        end
        rdy = '0;
        for (int i = 0; i < NS; i++) begin
            ai = a[i*AW +: AW];
            conf = 1'b0;
            if (ai != '0) begin
                for (int j = 0; j < NS; j++) begin
                    if (j != i && mFull[j] && j != g && mAddr[j] == ai) conf = 1'b1;
                    if (j < i && v[j] && rdy[j] && a[j*AW +: AW] == ai) conf = 1'b1;
                end
            end
            rdy[i] = (!mFull[i] || i == g) && !conf;
        end
        checkVal("src_ready", 64'(bus.src_ready), 64'(rdy));
        accepted = v & rdy;
        if (g >= 0) begin
            mRw = (mAddr[g] != '0);
            mWa = mAddr[g];
            mWd = mData[g];
            mFull[g] = 1'b0;
            mPtr = (g + 1) % NS;
        end else begin
            mRw = 1'b0;
        end
        for (int i = 0; i < NS; i++) begin
            if (accepted[i]) begin
                ai = a[i*AW +: AW];
                mFull[i] = 1'b1;
                mAddr[i] = ai;
                mData[i] = d[i*DW +: DW];
                if (ai != '0) lastAcc[ai] = d[i*DW +: DW];
            end
        end
    endtask

    task automatic idle(input int n, input logic [AW-1:0] r1);
        for (int i = 0; i < n; i++) stepCycle('0, '0, '0, r1, 5'd0);
    endtask

    initial begin
        int stage;
        int budget;
        bus.src_valid = '0;
        bus.src_addr  = '0;
        bus.src_data  = '0;
        bus.ReadRegster1 = '0;
        bus.ReadRegster2 = '0;
        doReset();

        // ALU alone writes r5
        stepCycle(3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0}, 5'd5, 5'd0);
        idle(2, 5'd5);
        checkVal("t2_we", 64'(bus.RegWrite), 64'd1);
        checkVal("t2_wa", 64'(bus.WriteRegster), 64'd5);
        checkVal("t2_wd", 64'(bus.WriteData), 64'hDEADBEEF);
        idle(3, 5'd5);
        checkVal("t2_file", 64'(tbFile[5]), 64'hDEADBEEF);

        // All three sources streaming to r1,r2,r3
        for (int n = 0; n < 12; n++)
            stepCycle(3'b111, {5'd3, 5'd2, 5'd1},
                      {32'h3000 + 32'(n), 32'h2000 + 32'(n), 32'h1000 + 32'(n)}, 5'd2, 5'd3);
        idle(4, 5'd0);

        // LOAD and ALU both target r7 in the same cycle
        stepCycle(3'b011, {5'd0, 5'd7, 5'd7}, {32'd0, 32'hB0B0_0002, 32'hA0A0_0001}, 5'd7, 5'd0);
        checkVal("t4_alu_blocked", 64'(bus.src_ready[SRC_ALU]), 64'd0);
        budget = 0;
        do begin
            stepCycle(3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'hB0B0_0002, 32'd0}, 5'd7, 5'd0);
            budget++;
        end while (!accepted[SRC_ALU] && budget < 10);
        checkVal("t4_alu_accepted", 64'(budget < 10), 64'd1);
        idle(4, 5'd7);
        checkVal("t4_r7", 64'(tbFile[7]), 64'hB0B0_0002);

        // HOST writes r0: drains without RegWrite
        stepCycle(3'b100, {5'd0, 5'd0, 5'd0}, {32'h1234, 32'd0, 32'd0}, 5'd0, 5'd0);
        idle(3, 5'd0);
        checkVal("t5_ready", 64'(bus.src_ready[SRC_HOST]), 64'd1);
        checkVal("t5_file_r0", 64'(tbFile[0]), 64'd0);

        // ALU writes r9=1 then r9=2 while LOAD floods r10
        stage = 0;
        for (int n = 0; n < 30 && stage < 2; n++) begin
            rV = (stage < 2) ? 3'b011 : 3'b001;
            stepCycle(rV, {5'd0, 5'd9, 5'd10},
                      {32'd0, (stage == 0) ? 32'd1 : 32'd2, 32'h100 + 32'(n)}, 5'd9, 5'd10);
            if (accepted[SRC_ALU]) stage++;
        end
        checkVal("t6_alu_done", 64'(stage), 64'd2);
        idle(6, 5'd9);
        checkVal("t6_r9", 64'(tbFile[9]), 64'd2);

        // Reset with all three slots full
        stepCycle(3'b111, {5'd13, 5'd12, 5'd11}, {32'hC3, 32'hC2, 32'hC1}, 5'd11, 5'd12);
        doReset();
        idle(4, 5'd11);
        checkVal("t1_r11_untouched", 64'(tbFile[11]), 64'd0);

        // Random traffic over a small address range to provoke conflicts
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                doReset();
            end else begin
                for (int i = 0; i < NS; i++) begin
                    rV[i] = ($urandom_range(0, 3) != 0);
                    rA[i*AW +: AW] = AW'($urandom_range(0, 7));
                    rD[i*DW +: DW] = $urandom();
                end
                stepCycle(rV, rA, rD, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            end
        end
        idle(6, 5'd0);
        for (int r = 0; r < 32; r++) checkVal("file", 64'(tbFile[r]), 64'(lastAcc[r]));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
